// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and SPI mode numbers.
package spi_pkg;

    // SPI mode numbers (CPOL, CPHA): 0=(0,0) 1=(0,1) 2=(1,0) 3=(1,1).
    localparam int SPI_MODE_0 = 0;
    localparam int SPI_MODE_1 = 1;
    localparam int SPI_MODE_2 = 2;
    localparam int SPI_MODE_3 = 3;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_SHIFT        = 2'd1,
        ST_WAIT_CS_HIGH = 2'd2
    } spi_slave_state_t;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with one extra history flop for edge detection.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   d_i       - asynchronous input
//   s2_o      - synchronized value
//   s3_o      - synchronized value delayed by one clk (edge history)
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic s2_o,
    output logic s3_o
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d_i;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign s2_o = s2_q;
    assign s3_o = s3_q;

endmodule : spi_sync_edge

// File: rtl/spi_slave.sv
// SPI mode-1 slave (CPOL=0, CPHA=1), oversampled by the system clock.
// Ports:
//   clk, rst              - system clock, synchronous active-high reset
//   sclk, cs, mosi        - SPI pins from the master (asynchronous)
//   miso                  - SPI data to the master, MSB first
//   tx_data, tx_load      - word for the next frame, accepted while tx_ready
//   tx_ready, busy        - FSM idle / not idle
//   rx_data, rx_valid     - last complete received word and its update pulse
//   tx_underrun           - pulse when a frame starts with no word loaded
//   frame_err             - pulse when cs rises before the frame completes
module spi_slave
    import spi_pkg::*;
#(
    parameter int          SPI_MODE    = SPI_MODE_1,
    parameter int unsigned SPI_TRF_BIT = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sclk,
    input  logic                   cs,
    input  logic                   mosi,
    output logic                   miso,
    input  logic [SPI_TRF_BIT-1:0] tx_data,
    input  logic                   tx_load,
    output logic                   tx_ready,
    output logic [SPI_TRF_BIT-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   tx_underrun,
    output logic                   frame_err
);

    localparam int unsigned CNT_W    = $clog2(SPI_TRF_BIT + 1);
    localparam int unsigned MSB      = SPI_TRF_BIT - 1;
    localparam int unsigned SETTLE_W = 2;
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = 2'd3;
    // An unsupported mode never starts a frame.
    localparam logic MODE_OK = (SPI_MODE == SPI_MODE_1);

    // Synchronizers
    logic sclk_s2, sclk_s3, cs_s2, cs_s3, mosi_s2, mosi_s3_unused;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(sclk), .s2_o(sclk_s2), .s3_o(sclk_s3)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(cs), .s2_o(cs_s2), .s3_o(cs_s3)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(mosi), .s2_o(mosi_s2), .s3_o(mosi_s3_unused)
    );

    logic sclk_rise, sclk_fall, cs_fall;
    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = sclk_s3 & ~sclk_s2;
    assign cs_fall   = cs_s3 & ~cs_s2;

    // State and datapath flops
    spi_slave_state_t       state_q, state_d;
    logic [SPI_TRF_BIT-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_TRF_BIT-1:0] rx_shift_q, rx_shift_d;
    logic [SPI_TRF_BIT-1:0] tx_buf_q, tx_buf_d;
    logic [SPI_TRF_BIT-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SETTLE_W-1:0]    settle_q, settle_d;
    logic                   tx_pending_q, tx_pending_d;
    logic                   miso_q, miso_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   busy_q, busy_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   frame_err_q, frame_err_d;

    // The synchronizers reset to cs high; a cs fall is only trusted once the
    // history flop holds a value that came from the pin, so a reset taken with
    // cs held low cannot restart the aborted frame.
    logic settled;
    assign settled = (settle_q == SETTLE_DONE);

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        tx_buf_d      = tx_buf_q;
        rx_data_d     = rx_data_q;
        bit_cnt_d     = bit_cnt_q;
        tx_pending_d  = tx_pending_q;
        miso_d        = miso_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_err_d   = 1'b0;
        settle_d      = settled ? settle_q : settle_q + SETTLE_W'(1);

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (tx_load) begin
                    tx_buf_d     = tx_data;
                    tx_pending_d = 1'b1;
                end
                if (cs_fall && settled && MODE_OK) begin
                    state_d       = ST_SHIFT;
                    // A load in this very cycle bypasses the buffer.
                    tx_shift_d    = tx_load      ? tx_data  :
                                    tx_pending_q ? tx_buf_q : '0;
                    tx_underrun_d = ~(tx_pending_q | tx_load);
                    tx_buf_d      = '0;
                    tx_pending_d  = 1'b0;
                    bit_cnt_d     = '0;
                    rx_shift_d    = '0;
                end
            end

            ST_SHIFT: begin
                if (cs_s2) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else begin
                    if (sclk_rise) begin
                        miso_d     = tx_shift_q[MSB];
                        tx_shift_d = {tx_shift_q[MSB-1:0], 1'b0};
                    end
                    if (sclk_fall) begin
                        rx_shift_d = {rx_shift_q[MSB-1:0], mosi_s2};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_d == CNT_W'(SPI_TRF_BIT)) begin
                            rx_data_d  = rx_shift_d;
                            rx_valid_d = 1'b1;
                            miso_d     = 1'b0;
                            state_d    = ST_WAIT_CS_HIGH;
                        end
                    end
                end
            end

            ST_WAIT_CS_HIGH: begin
                miso_d = 1'b0;
                if (cs_s2) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase

        busy_d     = (state_d != ST_IDLE);
        tx_ready_d = (state_d == ST_IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            tx_buf_q      <= '0;
            rx_data_q     <= '0;
            bit_cnt_q     <= '0;
            settle_q      <= '0;
            tx_pending_q  <= 1'b0;
            miso_q        <= 1'b0;
            rx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            tx_ready_q    <= 1'b1;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            tx_buf_q      <= tx_buf_d;
            rx_data_q     <= rx_data_d;
            bit_cnt_q     <= bit_cnt_d;
            settle_q      <= settle_d;
            tx_pending_q  <= tx_pending_d;
            miso_q        <= miso_d;
            rx_valid_q    <= rx_valid_d;
            busy_q        <= busy_d;
            tx_ready_q    <= tx_ready_d;
            tx_underrun_q <= tx_underrun_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign miso        = miso_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = busy_q;
    assign tx_ready    = tx_ready_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_err   = frame_err_q;

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave (12-bit frames, mode 1).
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [11:0] tx_data = '0;
    logic        tx_load = 1'b0;
    logic        tx_ready;
    logic [11:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        tx_underrun;
    logic        frame_err;

    spi_slave #(.SPI_MODE(1), .SPI_TRF_BIT(12)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .tx_underrun(tx_underrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rxv_cnt  = 0;
    int          udr_cnt  = 0;
    int          ferr_cnt = 0;
    logic [11:0] rx_log [0:15];
    logic [11:0] mbits;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rxv_cnt < 16) rx_log[rxv_cnt] <= rx_data;
            rxv_cnt <= rxv_cnt + 1;
        end
        if (tx_underrun) udr_cnt  <= udr_cnt + 1;
        if (frame_err)   ferr_cnt <= ferr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic [11:0] w);
        tx_data = w;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // One master frame, sclk half-period 8 clk. Options: stop after nfalls
    // falls, pulse rst after fall rst_at, load in the IDLE->SHIFT cycle,
    // pulse tx_load mid-frame, then hold cs high for gap clk.
    task automatic spi_frame(input logic [11:0] word, input int nfalls, input int rst_at,
                             input logic late_load, input logic [11:0] late_word,
                             input logic busy_load, input int gap);
        mbits = '0;
        cs = 1'b0;
        if (late_load) begin
            repeat (2) @(negedge clk);
            tx_data = late_word;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            repeat (5) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        if (busy_load) tx_data = 12'hFFF;
        for (int i = 0; i < 12; i++) begin
            if (i >= nfalls) break;
            sclk = 1'b1;
            mosi = word[11-i];
            repeat (8) @(negedge clk);
            mbits[11-i] = miso;
            sclk = 1'b0;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                tx_load = busy_load && (i == 3) && (j == 2);
            end
            tx_load = 1'b0;
            if (rst_at == i + 1) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                chk("rst_mid_tx_ready", 32'(tx_ready), 32'h1);
                chk("rst_mid_busy", 32'(busy), 32'h0);
                chk("rst_mid_miso", 32'(miso), 32'h0);
                chk("rst_mid_rx_data", 32'(rx_data), 32'h0);
                chk("rst_mid_rx_valid", 32'(rx_valid), 32'h0);
                chk("rst_mid_flags", 32'({tx_underrun, frame_err}), 32'h0);
                rst = 1'b0;
                @(negedge clk);
            end
        end
        repeat (8) @(negedge clk);
        cs = 1'b1;
        mosi = 1'b0;
        if (nfalls < 12) begin
            repeat (3) @(posedge clk);
            #1;
            chk("abort_tx_ready_3clk", 32'(tx_ready), 32'h1);
        end
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0, ud0, fe0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx_ready", 32'(tx_ready), 32'h1);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_miso", 32'(miso), 32'h0);
        chk("reset_rx_data", 32'(rx_data), 32'h0);
        chk("reset_pulses", 32'({rx_valid, tx_underrun, frame_err}), 32'h0);
        repeat (6) @(negedge clk);

        // Full frame
        rv0 = rxv_cnt; ud0 = udr_cnt; fe0 = ferr_cnt;
        load_word(12'hA5C);
        spi_frame(12'h3F1, 12, 0, 1'b0, 12'h000, 1'b0, 10);
        chk("full_rx_data", 32'(rx_data), 32'h3F1);
        chk("full_rx_valid_cnt", 32'(rxv_cnt - rv0), 32'd1);
        chk("full_miso_bits", 32'(mbits), 32'hA5C);
        chk("full_no_underrun", 32'(udr_cnt - ud0), 32'd0);
        chk("full_no_ferr", 32'(ferr_cnt - fe0), 32'd0);

        // Abort after 5 falls
        rv0 = rxv_cnt; fe0 = ferr_cnt;
        load_word(12'h123);
        spi_frame(12'hABC, 5, 0, 1'b0, 12'h000, 1'b0, 10);
        chk("abort_ferr_cnt", 32'(ferr_cnt - fe0), 32'd1);
        chk("abort_no_rx_valid", 32'(rxv_cnt - rv0), 32'd0);
        chk("abort_rx_data_held", 32'(rx_data), 32'h3F1);

        // Underrun
        rv0 = rxv_cnt; ud0 = udr_cnt;
        spi_frame(12'hFFF, 12, 0, 1'b0, 12'h000, 1'b0, 10);
        chk("udr_miso_zero", 32'(mbits), 32'h000);
        chk("udr_cnt", 32'(udr_cnt - ud0), 32'd1);
        chk("udr_rx_data", 32'(rx_data), 32'hFFF);

        // Back-to-back frames, cs high 4 clk between
        rv0 = rxv_cnt;
        spi_frame(12'h001, 12, 0, 1'b0, 12'h000, 1'b0, 4);
        spi_frame(12'h800, 12, 0, 1'b0, 12'h000, 1'b0, 10);
        chk("b2b_rx_valid_cnt", 32'(rxv_cnt - rv0), 32'd2);
        chk("b2b_word0", 32'(rx_log[rv0]), 32'h001);
        chk("b2b_word1", 32'(rx_log[rv0+1]), 32'h800);

        // Load while busy is ignored
        ud0 = udr_cnt;
        load_word(12'h5A5);
        spi_frame(12'h0F0, 12, 0, 1'b0, 12'h000, 1'b1, 10);
        chk("busyld_miso_bits", 32'(mbits), 32'h5A5);
        chk("busyld_rx_data", 32'(rx_data), 32'h0F0);
        spi_frame(12'h00F, 12, 0, 1'b0, 12'h000, 1'b0, 10);
        chk("busyld_next_miso_zero", 32'(mbits), 32'h000);
        chk("busyld_next_underrun", 32'(udr_cnt - ud0), 32'd1);

        // Load in the IDLE->SHIFT cycle
        ud0 = udr_cnt;
        spi_frame(12'h555, 12, 0, 1'b1, 12'h6C3, 1'b0, 10);
        chk("lateld_miso_bits", 32'(mbits), 32'h6C3);
        chk("lateld_no_underrun", 32'(udr_cnt - ud0), 32'd0);
        chk("lateld_rx_data", 32'(rx_data), 32'h555);

        // Reset at bit 6, then a clean frame
        rv0 = rxv_cnt; fe0 = ferr_cnt;
        load_word(12'h111);
        spi_frame(12'h7E7, 12, 6, 1'b0, 12'h000, 1'b0, 10);
        chk("rst_no_rx_valid", 32'(rxv_cnt - rv0), 32'd0);
        chk("rst_no_ferr", 32'(ferr_cnt - fe0), 32'd0);
        chk("rst_rx_data_cleared", 32'(rx_data), 32'h0);
        rv0 = rxv_cnt;
        load_word(12'h9C6);
        spi_frame(12'h2B7, 12, 0, 1'b0, 12'h000, 1'b0, 10);
        chk("post_rst_rx_data", 32'(rx_data), 32'h2B7);
        chk("post_rst_miso_bits", 32'(mbits), 32'h9C6);
        chk("post_rst_rx_valid_cnt", 32'(rxv_cnt - rv0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_slave
